// File: rtl/inv_bridge_guard_pkg.sv
// Shared inverter constants: leg FSM state encoding and default timing limits
// for the H-bridge dead-time / shoot-through guard.
package inv_bridge_guard_pkg;

    typedef enum logic [2:0] {
        ST_OFF  = 3'd0,
        ST_DT_H = 3'd1,
        ST_H_ON = 3'd2,
        ST_DT_L = 3'd3,
        ST_L_ON = 3'd4
    } leg_state_t;

    // 50 cycles = 1 us of dead time at 50 MHz
    localparam int DEAD_CYC_DEF   = 50;
    localparam int MIN_ON_CYC_DEF = 25;
    localparam int ST_LIMIT_DEF   = 10;

endpackage

// File: rtl/inv_bridge_guard_leg_deadtime.sv
// One half-bridge leg: dead-time insertion, minimum on-time hold and
// shoot-through detection with a consecutive-cycle counter.
module leg_deadtime
    import inv_bridge_guard_pkg::*;
#(
    parameter int DEAD_CYC   = DEAD_CYC_DEF,
    parameter int MIN_ON_CYC = MIN_ON_CYC_DEF,
    parameter int ST_LIMIT   = ST_LIMIT_DEF
) (
    input  logic CLK_50M,
    input  logic Rst_n,
    input  logic force_off,
    input  logic st_clr,
    input  logic cmd_h,
    input  logic cmd_l,
    output logic out_h,
    output logic out_l,
    output logic shoot,
    output logic st_hit
);

    localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYC - 1);
    localparam logic [7:0] ON_LOAD   = 8'(MIN_ON_CYC - 1);
    localparam logic [7:0] ST_THR    = 8'(ST_LIMIT - 1);

    leg_state_t state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [7:0] st_cnt;
    logic       out_h_nxt, out_l_nxt;

    assign shoot  = cmd_h & cmd_l;
    // Asserted on the cycle whose edge brings the consecutive count up to ST_LIMIT
    assign st_hit = shoot && (st_cnt >= ST_THR);

    always_ff @(posedge CLK_50M) begin
        if (!Rst_n) begin
            state  <= ST_OFF;
            cnt    <= 8'd0;
            out_h  <= 1'b0;
            out_l  <= 1'b0;
            st_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            out_h <= out_h_nxt;
            out_l <= out_l_nxt;
            if (st_clr || !shoot)
                st_cnt <= 8'd0;
            else if (st_cnt != 8'hFF)
                st_cnt <= st_cnt + 8'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (force_off || shoot) begin
            state_nxt = ST_OFF;
            cnt_nxt   = 8'd0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (cmd_h) begin
                        state_nxt = ST_DT_H;
                        cnt_nxt   = DEAD_LOAD;
                    end else if (cmd_l) begin
                        state_nxt = ST_DT_L;
                        cnt_nxt   = DEAD_LOAD;
                    end
                end
                ST_DT_H: begin
                    if (!cmd_h) begin
                        state_nxt = ST_OFF;
                        cnt_nxt   = 8'd0;
                    end else if (cnt == 8'd0) begin
                        state_nxt = ST_H_ON;
                        cnt_nxt   = ON_LOAD;
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
                ST_H_ON: begin
                    if (cnt != 8'd0)
                        cnt_nxt = cnt - 8'd1;
                    else if (!cmd_h)
                        state_nxt = ST_OFF;
                end
                ST_DT_L: begin
                    if (!cmd_l) begin
                        state_nxt = ST_OFF;
                        cnt_nxt   = 8'd0;
                    end else if (cnt == 8'd0) begin
                        state_nxt = ST_L_ON;
                        cnt_nxt   = ON_LOAD;
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
                ST_L_ON: begin
                    if (cnt != 8'd0)
                        cnt_nxt = cnt - 8'd1;
                    else if (!cmd_l)
                        state_nxt = ST_OFF;
                end
                default: begin
                    state_nxt = ST_OFF;
                    cnt_nxt   = 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        out_h_nxt = (state_nxt == ST_H_ON);
        out_l_nxt = (state_nxt == ST_L_ON);
    end

endmodule

// File: rtl/inv_bridge_guard.sv
// H-bridge gate guard: synchronizes DSP PWM commands, applies per-leg dead time,
// and latches a shoot-through fault that only a quiet Reset_D edge can clear.
module inv_bridge_guard
    import inv_bridge_guard_pkg::*;
#(
    parameter int DEAD_CYC   = DEAD_CYC_DEF,
    parameter int MIN_ON_CYC = MIN_ON_CYC_DEF,
    parameter int ST_LIMIT   = ST_LIMIT_DEF
) (
    input  logic       CLK_50M,
    input  logic       Rst_n,
    input  logic       En,
    input  logic       Reset_D,
    input  logic       PWM_LH_D,
    input  logic       PWM_LL_D,
    input  logic       PWM_RH_D,
    input  logic       PWM_RL_D,
    output logic       PWM_LH_C,
    output logic       PWM_LL_C,
    output logic       PWM_RH_C,
    output logic       PWM_RL_C,
    output logic       Fault,
    output logic [7:0] ShootCnt
);

    logic [4:0] async_in, sync1, sync2;
    logic       rst_d_prev;
    logic       fault;
    logic [7:0] shoot_cnt;
    logic       shoot_l, shoot_r, shoot_l_q, shoot_r_q;
    logic       st_hit_l, st_hit_r;
    logic       force_off, fault_clr, shoot_rise;

    assign async_in = {Reset_D, PWM_RL_D, PWM_RH_D, PWM_LL_D, PWM_LH_D};

    always_ff @(posedge CLK_50M) begin
        if (!Rst_n) begin
            sync1 <= 5'd0;
            sync2 <= 5'd0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
        end
    end

    // A Reset_D edge counts only when every synchronized command is idle
    assign fault_clr  = sync2[4] & ~rst_d_prev & (sync2[3:0] == 4'd0);
    assign force_off  = ~En | fault;
    assign shoot_rise = (shoot_l & ~shoot_l_q) | (shoot_r & ~shoot_r_q);

    always_ff @(posedge CLK_50M) begin
        if (!Rst_n) begin
            rst_d_prev <= 1'b0;
            fault      <= 1'b0;
            shoot_cnt  <= 8'd0;
            shoot_l_q  <= 1'b0;
            shoot_r_q  <= 1'b0;
        end else begin
            rst_d_prev <= sync2[4];
            shoot_l_q  <= shoot_l;
            shoot_r_q  <= shoot_r;
            if (st_hit_l || st_hit_r)
                fault <= 1'b1;
            else if (fault_clr)
                fault <= 1'b0;
            if (fault_clr)
                shoot_cnt <= 8'd0;
            else if (shoot_rise && shoot_cnt != 8'hFF)
                shoot_cnt <= shoot_cnt + 8'd1;
        end
    end

    assign Fault    = fault;
    assign ShootCnt = shoot_cnt;

    leg_deadtime #(
        .DEAD_CYC  (DEAD_CYC),
        .MIN_ON_CYC(MIN_ON_CYC),
        .ST_LIMIT  (ST_LIMIT)
    ) u_leg_left (
        .CLK_50M  (CLK_50M),
        .Rst_n    (Rst_n),
        .force_off(force_off),
        .st_clr   (fault_clr),
        .cmd_h    (sync2[0]),
        .cmd_l    (sync2[1]),
        .out_h    (PWM_LH_C),
        .out_l    (PWM_LL_C),
        .shoot    (shoot_l),
        .st_hit   (st_hit_l)
    );

    leg_deadtime #(
        .DEAD_CYC  (DEAD_CYC),
        .MIN_ON_CYC(MIN_ON_CYC),
        .ST_LIMIT  (ST_LIMIT)
    ) u_leg_right (
        .CLK_50M  (CLK_50M),
        .Rst_n    (Rst_n),
        .force_off(force_off),
        .st_clr   (fault_clr),
        .cmd_h    (sync2[2]),
        .cmd_l    (sync2[3]),
        .out_h    (PWM_RH_C),
        .out_l    (PWM_RL_C),
        .shoot    (shoot_r),
        .st_hit   (st_hit_r)
    );

endmodule

// File: tb/tb_inv_bridge_guard.sv
// Directed bench for inv_bridge_guard at default parameters; all expected
// cycle counts are hand-derived from the 2-flop sync + dead/min-on timing.
module tb_inv_bridge_guard;

    logic       CLK_50M = 1'b0;
    logic       Rst_n, En, Reset_D;
    logic       PWM_LH_D, PWM_LL_D, PWM_RH_D, PWM_RL_D;
    logic       PWM_LH_C, PWM_LL_C, PWM_RH_C, PWM_RL_C;
    logic       Fault;
    logic [7:0] ShootCnt;

    int vectors    = 0;
    int miscompares = 0;

    always #10 CLK_50M = ~CLK_50M;

    inv_bridge_guard dut (
        .CLK_50M (CLK_50M),
        .Rst_n   (Rst_n),
        .En      (En),
        .Reset_D (Reset_D),
        .PWM_LH_D(PWM_LH_D),
        .PWM_LL_D(PWM_LL_D),
        .PWM_RH_D(PWM_RH_D),
        .PWM_RL_D(PWM_RL_D),
        .PWM_LH_C(PWM_LH_C),
        .PWM_LL_C(PWM_LL_C),
        .PWM_RH_C(PWM_RH_C),
        .PWM_RL_C(PWM_RL_C),
        .Fault   (Fault),
        .ShootCnt(ShootCnt)
    );

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance n edges, landing 1 time unit after the last one; leg exclusivity is checked every cycle
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK_50M);
            #1;
            checkOutput("excl_left",  {7'd0, PWM_LH_C & PWM_LL_C}, 8'd0);
            checkOutput("excl_right", {7'd0, PWM_RH_C & PWM_RL_C}, 8'd0);
        end
    endtask

    task automatic applyStimulus(input logic lh, input logic ll, input logic rh, input logic rl);
        PWM_LH_D = lh;
        PWM_LL_D = ll;
        PWM_RH_D = rh;
        PWM_RL_D = rl;
    endtask

    task automatic checkGates(input string tag, input logic [3:0] expected);
        checkOutput(tag, {4'd0, PWM_LH_C, PWM_LL_C, PWM_RH_C, PWM_RL_C}, {4'd0, expected});
    endtask

    initial begin
        Rst_n   = 1'b0;
        En      = 1'b1;
        Reset_D = 1'b0;
        applyStimulus(0, 0, 0, 0);
        tick(3);
        checkGates("reset_gates", 4'b0000);
        checkOutput("reset_fault", {7'd0, Fault}, 8'd0);
        checkOutput("reset_shootcnt", ShootCnt, 8'd0);
        Rst_n = 1'b1;
        tick(2);

        // Rise latency 52 from sampling edge, fall latency 2
        applyStimulus(1, 0, 0, 0);
        tick(52);
        checkGates("lh_rise_early", 4'b0000);
        tick(1);
        checkGates("lh_rise", 4'b1000);
        tick(30);
        applyStimulus(0, 0, 0, 0);
        tick(2);
        checkGates("lh_fall_early", 4'b1000);
        tick(1);
        checkGates("lh_fall", 4'b0000);
        tick(5);

        // Short command still yields the full 25-cycle minimum on-time
        applyStimulus(1, 0, 0, 0);
        tick(53);
        checkGates("minon_start", 4'b1000);
        tick(9);
        applyStimulus(0, 0, 0, 0);
        tick(15);
        checkGates("minon_last", 4'b1000);
        tick(1);
        checkGates("minon_end", 4'b0000);
        tick(5);

        // H to L swap passes through OFF and a full dead time
        applyStimulus(1, 0, 0, 0);
        tick(53);
        checkGates("swap_h_on", 4'b1000);
        tick(30);
        applyStimulus(0, 1, 0, 0);
        tick(3);
        checkGates("swap_h_off", 4'b0000);
        tick(50);
        checkGates("swap_l_early", 4'b0000);
        tick(1);
        checkGates("swap_l_on", 4'b0100);
        applyStimulus(0, 0, 0, 0);
        tick(30);
        checkGates("swap_idle", 4'b0000);

        // Right-leg shoot-through: 9 cycles no fault, 10th latches it
        applyStimulus(0, 0, 1, 1);
        tick(11);
        checkGates("st9_gates", 4'b0000);
        checkOutput("st9_fault", {7'd0, Fault}, 8'd0);
        checkOutput("st9_shootcnt", ShootCnt, 8'd1);
        tick(1);
        checkOutput("st10_fault", {7'd0, Fault}, 8'd1);
        applyStimulus(1, 0, 0, 0);
        tick(60);
        checkGates("fault_hold_gates", 4'b0000);

        // Reset_D while a command is active is ignored
        Reset_D = 1'b1;
        tick(3);
        Reset_D = 1'b0;
        tick(3);
        checkOutput("clr_busy_fault", {7'd0, Fault}, 8'd1);
        checkOutput("clr_busy_shootcnt", ShootCnt, 8'd1);
        applyStimulus(0, 0, 0, 0);
        tick(3);
        Reset_D = 1'b1;
        tick(4);
        checkOutput("clr_fault", {7'd0, Fault}, 8'd0);
        checkOutput("clr_shootcnt", ShootCnt, 8'd0);
        Reset_D = 1'b0;
        tick(3);

        // Simultaneous shoot-through rise on both legs counts once
        applyStimulus(1, 1, 1, 1);
        tick(4);
        applyStimulus(0, 0, 0, 0);
        tick(3);
        checkOutput("both_rise_shootcnt", ShootCnt, 8'd1);
        checkOutput("both_rise_fault", {7'd0, Fault}, 8'd0);

        // En dropped mid on-time kills the output on the next edge
        applyStimulus(1, 0, 0, 0);
        tick(53);
        checkGates("en_h_on", 4'b1000);
        tick(5);
        En = 1'b0;
        tick(1);
        checkGates("en_drop", 4'b0000);
        tick(5);
        En = 1'b1;
        tick(50);
        checkGates("reenable_early", 4'b0000);
        tick(1);
        checkGates("reenable_on", 4'b1000);
        applyStimulus(0, 0, 0, 0);
        tick(30);

        // Rst_n in the middle of DT_L restarts the leg from OFF
        applyStimulus(0, 1, 0, 0);
        tick(20);
        Rst_n = 1'b0;
        tick(1);
        checkGates("rst_gates", 4'b0000);
        checkOutput("rst_shootcnt", ShootCnt, 8'd0);
        checkOutput("rst_fault", {7'd0, Fault}, 8'd0);
        Rst_n = 1'b1;
        tick(52);
        checkGates("rst_l_early", 4'b0000);
        tick(1);
        checkGates("rst_l_on", 4'b0100);
        applyStimulus(0, 0, 0, 0);
        tick(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inv_bridge_guard.md
INV_BRIDGE_GUARD -- requirements
Module: inv_bridge_guard

Interface
REQ-001 Parameter DEAD_CYC, default 50: dead-time cycles (1 us at 50 MHz); legal range 1..255.
REQ-002 Parameter MIN_ON_CYC, default 25: minimum on-time cycles for any switch; legal range 1..255.
REQ-003 Parameter ST_LIMIT, default 10: consecutive shoot-through command cycles that latch Fault; legal range 1..255.
REQ-004 Port CLK_50M, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port Rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 Port En, input, 1 bit: bridge enable from the protection counters; 1 = switching allowed.
REQ-007 Port Reset_D, input, 1 bit: DSP fault-clear request, asynchronous to CLK_50M.
REQ-008 Ports PWM_LH_D, PWM_LL_D, PWM_RH_D, PWM_RL_D, input, 1 bit each: DSP gate commands (left/right leg, high/low switch), asynchronous.
REQ-009 Ports PWM_LH_C, PWM_LL_C, PWM_RH_C, PWM_RL_C, output, 1 bit each: registered gate drives to the drivers.
REQ-010 Port Fault, output, 1 bit: latched shoot-through fault.
REQ-011 Port ShootCnt, output, 8 bits: saturating count of shoot-through command events.

Function
REQ-012 Each D input and Reset_D SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized copies.
REQ-013 Each leg SHALL run an independent FSM with states OFF, DT_H, H_ON, DT_L, L_ON; high output = (state==H_ON), low output = (state==L_ON); outputs are registered from the next state.
REQ-014 In OFF with cmd_h=1 and cmd_l=0, the FSM SHALL go to DT_H and load the dead counter with DEAD_CYC-1; DT_L is symmetric for cmd_l.
REQ-015 In DT_H, the FSM SHALL go to H_ON when the counter is 0 and cmd_h is still 1; if cmd_h drops, it SHALL return to OFF; otherwise it SHALL decrement.
REQ-016 On H_ON entry, the FSM SHALL load the on counter with MIN_ON_CYC-1.
REQ-017 The FSM SHALL leave H_ON for OFF only when cmd_h=0 and the on counter is 0; L_ON is symmetric.
REQ-018 A direct command swap (H to L) SHALL pass through OFF, so every turn-on is preceded by the full DEAD_CYC.
REQ-019 Latency from the first clock edge that samples an input edge SHALL be DEAD_CYC+2 cycles for a rise and 2 cycles for a fall (min-on satisfied).
REQ-020 Shoot-through command (synchronized cmd_h=1 and cmd_l=1 on one leg) SHALL force that leg to OFF on the next edge, overriding the min-on hold.
REQ-021 A per-leg counter SHALL count consecutive shoot-through cycles and reset to 0 on any non-shoot-through cycle; reaching ST_LIMIT SHALL set Fault.
REQ-022 ShootCnt SHALL increment on each rising edge of either leg's shoot-through condition, saturate at 255, and count simultaneous rises on both legs as +1.
REQ-023 En=0 or Fault=1 SHALL force both FSMs to OFF and all outputs to 0 on the next edge and hold them there.
REQ-024 Re-enable (En 0 to 1) SHALL apply the full dead time before any output rises.
REQ-025 Fault SHALL clear only on a synchronized Reset_D rising edge while all four synchronized commands are 0.
REQ-026 The same Reset_D edge SHALL clear ShootCnt and both shoot-through counters; a Reset_D edge under any other condition SHALL be ignored.
REQ-027 At no cycle SHALL the high and low outputs of the same leg both be 1.

Reset
REQ-028 With Rst_n=0 at a clock edge: all outputs 0, Fault=0, ShootCnt=0, FSMs in OFF, all counters 0, synchronizers 0; normal operation starts on the first edge with Rst_n=1.

Structure
REQ-029 FSM state encodings and the default DEAD_CYC, MIN_ON_CYC and ST_LIMIT values SHALL live in the shared inverter constants include file.
REQ-030 Per-leg logic SHALL be one sub-module, leg_deadtime, instantiated twice; Fault, ShootCnt and the Reset_D edge detection stay in the top.

Verification
REQ-031 Defaults, PWM_LH_D rises with others 0 -> PWM_LH_C rises exactly 52 cycles later; falls 2 cycles after PWM_LH_D falls.
REQ-032 PWM_LH_D high for 10 cycles (after the dead time) -> PWM_LH_C high for exactly 25 cycles.
REQ-033 PWM_LH_D to PWM_LL_D swap on the same edge -> PWM_LH_C low, then PWM_LL_C rises 51 cycles later; both never high together.
REQ-034 PWM_RH_D and PWM_RL_D both high for 9 cycles -> right outputs 0, Fault=0, ShootCnt=1; held for 10 cycles -> Fault=1, all outputs 0.
REQ-035 Fault=1, Reset_D pulse while PWM_LH_D=1 -> Fault stays 1; Reset_D pulse with all commands 0 -> Fault=0 and ShootCnt=0 within 4 cycles.
REQ-036 En dropped mid H_ON -> output low next edge; Rst_n=0 mid DT_L -> all outputs 0 and FSMs in OFF after the edge.
